// File: rtl/mem_sequencer_pkg.sv
// Shared types and constants for the unified-memory fetch/data sequencer.
package mem_sequencer_pkg;

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StData,
        StCommit,
        StHalt,
        StErr
    } seq_state_e;

    localparam logic [31:0] InstrNop = 32'h0000_0013;
    localparam logic [2:0]  ModeWord = 3'b010;

    // States that own the memory port and are covered by the watchdog.
    function automatic logic is_bus_state(seq_state_e s);
        return (s == StFetch) || (s == StData);
    endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Counts stalled request cycles; flags expiry on the cycle that would reach TIMEOUT.
module bus_watchdog #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic wait_cyc,
    output logic expired
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (wait_cyc) begin
            cnt_d = cnt_q + 1'b1;
        end
        // Expire during the TIMEOUT-th stalled cycle so the request never exceeds TIMEOUT cycles.
        expired = (TIMEOUT != 0) && wait_cyc && (cnt_q == CntLast);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_sequencer.sv
// Shares one single-port memory between instruction fetch and load/store, one
// instruction per FETCH -> DECODE -> [DATA] -> COMMIT sequence.
module mem_sequencer
    import mem_sequencer_pkg::*;
#(
    parameter int unsigned N        = 32,
    parameter int unsigned MEM_ADDR = 8,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [MEM_ADDR-1:0] pc_addr,
    input  logic                d_rd,
    input  logic                d_wr,
    input  logic [2:0]          d_read_mode,
    input  logic [1:0]          d_write_mode,
    input  logic [MEM_ADDR-1:0] d_addr,
    input  logic [N-1:0]        d_wdata,
    input  logic                halt_req,
    output logic [N-1:0]        ir,
    output logic [N-1:0]        d_rdata,
    output logic                pc_load,
    output logic                wb_en,
    output logic                halted,
    output logic                bus_err,
    output logic                m_req,
    output logic                m_we,
    output logic [MEM_ADDR-1:0] m_addr,
    output logic [N-1:0]        m_wdata,
    output logic [2:0]          m_read_mode,
    output logic [1:0]          m_write_mode,
    input  logic [N-1:0]        m_rdata,
    input  logic                m_ready
);

    seq_state_e          state_q, state_d;
    logic [N-1:0]        ir_q, ir_d;
    logic [N-1:0]        d_rdata_q, d_rdata_d;
    logic [MEM_ADDR-1:0] m_addr_q;
    logic [N-1:0]        m_wdata_q;
    logic [2:0]          m_read_mode_q;
    logic [1:0]          m_write_mode_q;
    logic                in_fetch, in_data, done, wait_cyc, expired;

    bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_bus_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clr      (!is_bus_state(state_q)),
        .wait_cyc (wait_cyc),
        .expired  (expired)
    );

    // Port outputs: driven live in FETCH/DATA, otherwise the last driven values.
    // Gating with rst drops the request asynchronously while reset is held.
    always_comb begin
        in_fetch     = rst && (state_q == StFetch);
        in_data      = rst && (state_q == StData);
        m_req        = in_fetch || in_data;
        m_we         = in_data && d_wr;
        m_addr       = m_addr_q;
        m_wdata      = m_wdata_q;
        m_read_mode  = m_read_mode_q;
        m_write_mode = m_write_mode_q;
        if (in_fetch) begin
            m_addr       = pc_addr;
            m_read_mode  = ModeWord;
            m_write_mode = 2'b00;
        end else if (in_data) begin
            m_addr       = d_addr;
            m_wdata      = d_wdata;
            m_read_mode  = d_read_mode;
            m_write_mode = d_write_mode;
        end
        done     = m_req && m_ready;
        wait_cyc = m_req && !m_ready;
        pc_load  = (state_q == StCommit);
        wb_en    = (state_q == StCommit);
        halted   = (state_q == StHalt);
        bus_err  = (state_q == StErr);
        ir       = ir_q;
        d_rdata  = d_rdata_q;
    end

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        d_rdata_d = d_rdata_q;
        unique case (state_q)
            StFetch: begin
                if (done) begin
                    ir_d    = m_rdata;
                    state_d = StDecode;
                end else if (expired) begin
                    state_d = StErr;
                end
            end
            StDecode: state_d = (d_rd || d_wr) ? StData : StCommit;
            StData: begin
                if (done) begin
                    // A simultaneous store takes the port, so the load data is not captured.
                    if (d_rd && !d_wr) begin
                        d_rdata_d = m_rdata;
                    end
                    state_d = StCommit;
                end else if (expired) begin
                    state_d = StErr;
                end
            end
            StCommit: state_d = halt_req ? StHalt : StFetch;
            StHalt: begin
                if (!halt_req) begin
                    state_d = StFetch;
                end
            end
            StErr:   state_d = StErr;
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= StFetch;
            ir_q           <= N'(InstrNop);
            d_rdata_q      <= '0;
            m_addr_q       <= '0;
            m_wdata_q      <= '0;
            m_read_mode_q  <= '0;
            m_write_mode_q <= '0;
        end else begin
            state_q        <= state_d;
            ir_q           <= ir_d;
            d_rdata_q      <= d_rdata_d;
            m_addr_q       <= m_addr;
            m_wdata_q      <= m_wdata;
            m_read_mode_q  <= m_read_mode;
            m_write_mode_q <= m_write_mode;
        end
    end

endmodule

// File: tb/tb_mem_sequencer.sv
// Scoreboard bench: stimulus pushes expected bus transactions and commits, a monitor checks them.
module tb_mem_sequencer;

    localparam int unsigned N   = 32;
    localparam int unsigned MA  = 8;
    localparam int unsigned TO  = 4;
    localparam int          NUM = 40;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [MA-1:0] pc_addr = '0, d_addr = '0, m_addr;
    logic          d_rd = 1'b0, d_wr = 1'b0, halt_req = 1'b0;
    logic [2:0]    d_read_mode = '0, m_read_mode;
    logic [1:0]    d_write_mode = '0, m_write_mode;
    logic [N-1:0]  d_wdata = '0, ir, d_rdata, m_wdata;
    logic [N-1:0]  m_rdata = '0;
    logic          m_ready = 1'b0;
    logic          pc_load, wb_en, halted, bus_err, m_req, m_we;

    always #5 clk = ~clk;

    mem_sequencer #(
        .N        (N),
        .MEM_ADDR (MA),
        .TIMEOUT  (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_addr      (pc_addr),
        .d_rd         (d_rd),
        .d_wr         (d_wr),
        .d_read_mode  (d_read_mode),
        .d_write_mode (d_write_mode),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .halt_req     (halt_req),
        .ir           (ir),
        .d_rdata      (d_rdata),
        .pc_load      (pc_load),
        .wb_en        (wb_en),
        .halted       (halted),
        .bus_err      (bus_err),
        .m_req        (m_req),
        .m_we         (m_we),
        .m_addr       (m_addr),
        .m_wdata      (m_wdata),
        .m_read_mode  (m_read_mode),
        .m_write_mode (m_write_mode),
        .m_rdata      (m_rdata),
        .m_ready      (m_ready)
    );

    typedef struct {
        logic [7:0]  addr;
        logic        we;
        logic [31:0] wdata;
        logic [2:0]  rmode;
        logic [1:0]  wmode;
        logic        is_data;
    } txn_t;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] rdata;
        int          lat;
    } cmt_t;

    typedef struct {
        logic [7:0]  pc;
        logic [7:0]  addr;
        logic        rd;
        logic        wr;
        logic [31:0] wdata;
        logic [2:0]  rmode;
        logic [1:0]  wmode;
        int          wf;
        int          wd;
        bit          halt;
        int          hk;
    } ins_t;

    logic [31:0] mem [64];
    txn_t        txn_q[$];
    cmt_t        cmt_q[$];
    int          wait_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          busy = 1'b0;
    int          wait_left = 0;
    logic [31:0] exp_rdata = '0;
    txn_t        mt;
    cmt_t        mc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model: wait counts come from the stimulus, read data from mem[].
    always @(negedge clk) begin
        if (!rst) begin
            m_ready = 1'b0;
            busy    = 1'b0;
        end else if (m_req) begin
            if (!busy) begin
                busy      = 1'b1;
                wait_left = (wait_q.size() > 0) ? wait_q.pop_front() : 0;
            end
            if (wait_left == 0) begin
                m_ready = 1'b1;
                m_rdata = mem[m_addr[7:2]];
                busy    = 1'b0;
            end else begin
                m_ready = 1'b0;
                m_rdata = $urandom;
                wait_left--;
            end
        end else begin
            m_ready = 1'b0;
            m_rdata = $urandom;
        end
    end

    // Monitor: pops the scoreboard on every completed transfer and every commit.
    always begin
        @(negedge clk);
        #1;
        if (rst) begin
            cyc++;
            if (m_req && m_ready) begin
                if (txn_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_txn: got addr %h expected none", m_addr);
                end else begin
                    mt = txn_q.pop_front();
                    chk("txn_addr", 32'(m_addr), 32'(mt.addr));
                    chk("txn_we", 32'(m_we), 32'(mt.we));
                    chk("txn_rmode", 32'(m_read_mode), 32'(mt.rmode));
                    if (mt.is_data) chk("txn_wmode", 32'(m_write_mode), 32'(mt.wmode));
                    if (mt.we) chk("txn_wdata", m_wdata, mt.wdata);
                end
            end
            if (pc_load) begin
                chk("wb_en_commit", 32'(wb_en), 32'd1);
                if (cmt_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_commit: got ir %h expected none", ir);
                end else begin
                    mc = cmt_q.pop_front();
                    chk("commit_ir", ir, mc.ir);
                    chk("commit_rdata", d_rdata, mc.rdata);
                    chk("commit_latency", 32'(cyc), 32'(mc.lat));
                end
                cyc = 0;
            end else begin
                chk("wb_en_idle", 32'(wb_en), 32'd0);
            end
        end
    end

    function automatic ins_t pick(input int idx);
        ins_t x;
        int   kind;
        x.pc    = {2'(0), 6'($urandom_range(0, 63))} << 2;
        x.addr  = {2'(0), 6'($urandom_range(0, 63))} << 2;
        kind    = $urandom_range(0, 3);
        x.rd    = (kind == 1) || (kind == 3);
        x.wr    = (kind == 2) || (kind == 3);
        x.wdata = $urandom;
        x.rmode = 3'($urandom_range(0, 7));
        x.wmode = 2'($urandom_range(0, 3));
        x.wf    = $urandom_range(0, 3);
        x.wd    = $urandom_range(0, 3);
        x.halt  = ($urandom_range(0, 5) == 0);
        x.hk    = $urandom_range(1, 4);
        if (x.halt && x.wf == 0) x.wf = 2;
        if (idx == 0) begin
            x.pc = 8'h00; x.rd = 1'b0; x.wr = 1'b0; x.wf = 0; x.halt = 1'b0;
        end else if (idx == 1) begin
            x.addr = 8'h20; x.rd = 1'b1; x.wr = 1'b0; x.rmode = 3'b010;
            x.wf = 0; x.wd = 2; x.halt = 1'b0;
        end else if (idx == 2) begin
            x.rd = 1'b0; x.wr = 1'b1; x.wdata = 32'h1234_5678; x.wmode = 2'b10;
            x.halt = 1'b0;
        end else if (idx == 3) begin
            x.halt = 1'b1; x.wf = 3; x.hk = 3;
        end
        return x;
    endfunction

    // Drive one instruction's inputs and push everything it should produce.
    task automatic issue(input ins_t x, input int extra);
        txn_t t;
        cmt_t c;
        bit   dat;
        dat          = x.rd || x.wr;
        pc_addr      = x.pc;
        d_rd         = x.rd;
        d_wr         = x.wr;
        d_addr       = x.addr;
        d_wdata      = x.wdata;
        d_read_mode  = x.rmode;
        d_write_mode = x.wmode;
        t.addr = x.pc; t.we = 1'b0; t.wdata = '0; t.rmode = 3'b010; t.wmode = '0;
        t.is_data = 1'b0;
        txn_q.push_back(t);
        wait_q.push_back(x.wf);
        if (dat) begin
            t.addr = x.addr; t.we = x.wr; t.wdata = x.wdata; t.rmode = x.rmode;
            t.wmode = x.wmode; t.is_data = 1'b1;
            txn_q.push_back(t);
            wait_q.push_back(x.wd);
            if (x.rd && !x.wr) exp_rdata = mem[x.addr[7:2]];
        end
        c.ir    = mem[x.pc[7:2]];
        c.rdata = exp_rdata;
        c.lat   = extra + 3 + x.wf + (dat ? 1 + x.wd : 0);
        cmt_q.push_back(c);
    endtask

    task automatic wait_commit(output bit ok);
        ok = 1'b0;
        for (int j = 0; j < 60; j++) begin
            @(negedge clk);
            if (pc_load) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL commit_timeout: got no pc_load expected one within 60 cycles");
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_m_req"}, 32'(m_req), 32'd0);
        chk({tag, "_ir"}, ir, 32'h0000_0013);
        chk({tag, "_d_rdata"}, d_rdata, 32'd0);
        chk({tag, "_m_addr"}, 32'(m_addr), 32'd0);
        chk({tag, "_m_wdata"}, m_wdata, 32'd0);
        chk({tag, "_m_we"}, 32'(m_we), 32'd0);
        chk({tag, "_modes"}, 32'({m_read_mode, m_write_mode}), 32'd0);
        chk({tag, "_pulses"}, 32'({pc_load, wb_en}), 32'd0);
        chk({tag, "_status"}, 32'({halted, bus_err}), 32'd0);
    endtask

    task automatic flush();
        txn_q.delete();
        cmt_q.delete();
        wait_q.delete();
        exp_rdata = '0;
        cyc       = 0;
    endtask

    initial begin
        ins_t cur, nxt;
        bit   ok;
        bit   abort;
        int   reqs, loads;
        abort = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0] = 32'h0050_0093;
        mem[8] = 32'hDEAD_BEEF;

        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        cur = pick(0);
        issue(cur, 0);
        @(posedge clk);
        #1 rst = 1'b1;

        for (int n = 0; n < NUM; n++) begin
            if (cur.halt) begin
                @(negedge clk);
                halt_req = 1'b1;
            end
            wait_commit(ok);
            if (!ok) begin
                abort = 1'b1;
                break;
            end
            if (n < NUM - 1) begin
                nxt = pick(n + 1);
                issue(nxt, cur.halt ? cur.hk : 0);
            end else begin
                // Final fetch is never answered so the watchdog must fire.
                pc_addr = 8'h40;
                d_rd    = 1'b0;
                d_wr    = 1'b0;
                wait_q.push_back(1000);
            end
            if (cur.halt) begin
                for (int j = 1; j <= cur.hk; j++) begin
                    @(negedge clk);
                    chk("halt_halted", 32'(halted), 32'd1);
                    chk("halt_no_req", 32'(m_req), 32'd0);
                    if (j == cur.hk) halt_req = 1'b0;
                end
            end
            cur = nxt;
        end

        if (!abort) begin
            reqs  = 0;
            loads = 0;
            for (int j = 0; j < 14; j++) begin
                @(negedge clk);
                if (m_req) reqs++;
                if (pc_load) loads++;
            end
            chk("timeout_req_cycles", 32'(reqs), 32'(TO));
            chk("timeout_no_pc_load", 32'(loads), 32'd0);
            chk("timeout_bus_err", 32'(bus_err), 32'd1);
            chk("timeout_m_req", 32'(m_req), 32'd0);

            @(negedge clk);
            rst = 1'b0;
            #1;
            chk("err_reset_bus_err", 32'(bus_err), 32'd0);
            flush();

            // Load that gets reset while stalled in DATA.
            nxt      = pick(10);
            nxt.pc   = 8'h04; nxt.addr = 8'h44; nxt.rd = 1'b1; nxt.wr = 1'b0;
            nxt.wf   = 0; nxt.wd = 3; nxt.halt = 1'b0;
            issue(nxt, 0);
            @(posedge clk);
            #1 rst = 1'b1;
            repeat (3) @(negedge clk);
            #2;
            chk("data_m_req", 32'(m_req), 32'd1);
            chk("data_m_addr", 32'(m_addr), 32'h44);
            rst = 1'b0;
            #1;
            check_reset_vals("mid_data");
            flush();

            nxt      = pick(11);
            nxt.halt = 1'b0;
            issue(nxt, 0);
            repeat (2) @(negedge clk);
            @(posedge clk);
            #1 rst = 1'b1;
            wait_commit(ok);
            @(negedge clk);
        end

        chk("txn_q_drained", 32'(txn_q.size()), 32'd0);
        chk("cmt_q_drained", 32'(cmt_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1, "bench timed out");
    end

endmodule
